// File: rtl/chi_txflit_mgmt_mc_if.sv
// rtl/chi_txflit_mgmt_mc_if.sv - buffer-read, link and status bundle of the multi-channel TX flit manager
interface chi_txflit_mgmt_mc_if #(
  parameter int NUM_CH  = 3,
  parameter int DEPTH   = 15,
  parameter int MAX_CRD = 15
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW  = $clog2(MAX_CRD + 1);

  logic [NUM_CH*DEPTH-1:0] own_flit;
  logic                    link_up;
  logic [NUM_CH-1:0]       lcrd_v;
  logic                    rd_vld;
  logic                    read_req;
  logic [CHW-1:0]          read_ch;
  logic [AW-1:0]           read_addr;
  logic                    flit_pending;
  logic [NUM_CH-1:0]       flit_valid;
  logic [NUM_CH*DEPTH-1:0] ownership;
  logic [NUM_CH*CW-1:0]    credit_cnt;

  modport master (
    output own_flit, link_up, lcrd_v, rd_vld,
    input  read_req, read_ch, read_addr, flit_pending, flit_valid, ownership, credit_cnt
  );

  modport slave (
    input  own_flit, link_up, lcrd_v, rd_vld,
    output read_req, read_ch, read_addr, flit_pending, flit_valid, ownership, credit_cnt
  );
endinterface

// File: rtl/chi_txflit_mgmt_mc.sv
// rtl/chi_txflit_mgmt_mc.sv - multi-channel CHI TX flit ownership, credit and round-robin send manager
module chi_txflit_mgmt_mc #(
  parameter int NUM_CH  = 3,
  parameter int DEPTH   = 15,
  parameter int MAX_CRD = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  chi_txflit_mgmt_mc_if.slave   bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW  = $clog2(MAX_CRD + 1);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, SEND} state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0][DEPTH-1:0] own_q, own_d;
  logic [NUM_CH-1:0][CW-1:0]    crd_q, crd_d;
  logic [NUM_CH-1:0][AW-1:0]    ptr_q, ptr_d;
  logic [CHW-1:0]               rr_q, rr_d;
  logic [CHW-1:0]               grant_q;
  logic [CHW-1:0]               sel;
  logic [NUM_CH-1:0]            elig;
  logic                         any_elig;
  logic                         send_ok;
  logic                         issue, fire, pending;
  logic                         read_req_q;
  logic [CHW-1:0]               read_ch_q;
  logic [AW-1:0]                read_addr_q;
  logic [NUM_CH-1:0]            fv_d, flit_valid_q;

  // A channel may be picked when its next slot is owned, it holds a credit and the link is up
  always_comb begin
    elig = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      elig[ch] = own_q[ch][ptr_q[ch]] && (crd_q[ch] != '0) && bus.link_up;
    end
  end

  // Round-robin pick: scan from the far end back so the lowest offset from rr_q wins
  always_comb begin
    int             idx;
    logic [CHW-1:0] cand;
    sel      = '0;
    any_elig = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CHW'(idx);
      if (elig[cand]) begin
        sel      = cand;
        any_elig = 1'b1;
      end
    end
  end

  // The held flit can go out only while the link is up and its channel still has a credit
  assign send_ok = bus.link_up && (crd_q[grant_q] != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (any_elig)   state_d = WAIT_DATA;
      WAIT_DATA: if (bus.rd_vld) state_d = SEND;
      SEND:      if (send_ok)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // FSM control strobes: issue a buffer read, fire a send, flag an in-flight flit
  always_comb begin
    issue   = 1'b0;
    fire    = 1'b0;
    pending = 1'b0;
    case (state_q)
      IDLE:      issue = any_elig;
      WAIT_DATA: pending = 1'b1;
      SEND: begin
        pending = 1'b1;
        fire    = send_ok;
      end
      default: ;
    endcase
  end

  // Next ownership, credit, read-pointer and priority values; a send clears after any new grant
  always_comb begin
    own_d = own_q | bus.own_flit;
    ptr_d = ptr_q;
    rr_d  = rr_q;
    fv_d  = '0;
    if (fire) begin
      own_d[grant_q][ptr_q[grant_q]] = 1'b0;
      ptr_d[grant_q] = (ptr_q[grant_q] == AW'(DEPTH - 1)) ? '0 : ptr_q[grant_q] + 1'b1;
      rr_d           = (grant_q == CHW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
      fv_d[grant_q]  = 1'b1;
    end
    crd_d = crd_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!bus.link_up) begin
        crd_d[ch] = '0;
      end else if (fire && (grant_q == CHW'(ch))) begin
        if (!bus.lcrd_v[ch]) crd_d[ch] = crd_q[ch] - 1'b1;
      end else if (bus.lcrd_v[ch] && (crd_q[ch] != CW'(MAX_CRD))) begin
        crd_d[ch] = crd_q[ch] + 1'b1;
      end
    end
  end

  // Datapath registers; read_ch/read_addr only move when a new read is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      own_q        <= '0;
      crd_q        <= '0;
      ptr_q        <= '0;
      rr_q         <= '0;
      grant_q      <= '0;
      read_req_q   <= 1'b0;
      read_ch_q    <= '0;
      read_addr_q  <= '0;
      flit_valid_q <= '0;
    end else begin
      own_q        <= own_d;
      crd_q        <= crd_d;
      ptr_q        <= ptr_d;
      rr_q         <= rr_d;
      read_req_q   <= issue;
      flit_valid_q <= fv_d;
      if (issue) begin
        grant_q     <= sel;
        read_ch_q   <= sel;
        read_addr_q <= ptr_q[sel];
      end
    end
  end

  assign bus.read_req     = read_req_q;
  assign bus.read_ch      = read_ch_q;
  assign bus.read_addr    = read_addr_q;
  assign bus.flit_pending = pending;
  assign bus.flit_valid   = flit_valid_q;
  assign bus.ownership    = own_q;
  assign bus.credit_cnt   = crd_q;
endmodule

// File: tb/tb_chi_txflit_mgmt_mc.sv
// tb/tb_chi_txflit_mgmt_mc.sv - self-checking bench for chi_txflit_mgmt_mc
module tb_chi_txflit_mgmt_mc;
  localparam int NUM_CH = 3, DEPTH = 15, MAX_CRD = 15;
  localparam int AW = 4, CHW = 2, CW = 4, NB = NUM_CH * DEPTH;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  chi_txflit_mgmt_mc_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .MAX_CRD(MAX_CRD)) bus ();
  chi_txflit_mgmt_mc #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .MAX_CRD(MAX_CRD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // reference model: transaction-level ownership/credit/pointer bookkeeping
  int m_own[NUM_CH][DEPTH];
  int m_crd[NUM_CH];
  int m_ptr[NUM_CH];
  int m_rr;
  int exp_ch[$];
  int exp_addr[$];

  // results of the last serve()
  logic             s_to_r, s_to_f, s_req2;
  logic [CHW-1:0]   s_ch;
  logic [AW-1:0]    s_addr;
  logic [NUM_CH-1:0] s_fv;
  int               s_lat;

  function automatic int crd_of(int ch);
    return int'(bus.credit_cnt[ch*CW +: CW]);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_crd[c] = 0;
      m_ptr[c] = 0;
      for (int i = 0; i < DEPTH; i++) m_own[c][i] = 0;
    end
    m_rr = 0;
  endfunction

  function automatic void model_plan();
    int g, c;
    exp_ch.delete();
    exp_addr.delete();
    while (1'b1) begin
      g = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (g < 0 && m_own[c][m_ptr[c]] != 0 && m_crd[c] > 0) g = c;
      end
      if (g < 0) break;
      exp_ch.push_back(g);
      exp_addr.push_back(m_ptr[g]);
      m_own[g][m_ptr[g]] = 0;
      m_crd[g] = m_crd[g] - 1;
      m_ptr[g] = (m_ptr[g] + 1) % DEPTH;
      m_rr = (g + 1) % NUM_CH;
    end
  endfunction

  function automatic logic [NB-1:0] model_own_vec();
    logic [NB-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < DEPTH; i++) v[c*DEPTH+i] = (m_own[c][i] != 0);
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.own_flit = '0; bus.link_up = 1'b0; bus.lcrd_v = '0; bus.rd_vld = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_read_req();
    s_to_r = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (bus.read_req === 1'b1) begin
        s_to_r = 1'b0; s_ch = bus.read_ch; s_addr = bus.read_addr;
        break;
      end
      tick();
    end
  endtask

  // wait for a read, answer it after 'delay' cycles, drive 'coin' on lcrd_v in the SEND cycle
  task automatic serve(input int delay, input logic [NUM_CH-1:0] coin);
    s_to_f = 1'b1; s_fv = '0; s_lat = 0; s_req2 = 1'b0;
    wait_read_req();
    if (s_to_r) return;
    tick();
    s_req2 = bus.read_req;
    repeat (delay - 1) tick();
    bus.rd_vld = 1'b1;
    tick();
    bus.rd_vld = 1'b0;
    bus.lcrd_v = coin;
    for (int i = 1; i < 16; i++) begin
      if (bus.flit_valid !== '0) begin
        s_to_f = 1'b0; s_fv = bus.flit_valid; s_lat = i;
        break;
      end
      tick();
      bus.lcrd_v = '0;
    end
    bus.lcrd_v = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.own_flit = '1; bus.link_up = 1'b1; bus.lcrd_v = '1; bus.rd_vld = 1'b1;
    repeat (2) tick();
    n_checks++; if (bus.read_req !== 1'b0) begin n_fail++; $display("FAIL reset_read_req: got %0h expected 0", bus.read_req); end
    n_checks++; if (bus.read_ch !== '0) begin n_fail++; $display("FAIL reset_read_ch: got %0h expected 0", bus.read_ch); end
    n_checks++; if (bus.read_addr !== '0) begin n_fail++; $display("FAIL reset_read_addr: got %0h expected 0", bus.read_addr); end
    n_checks++; if (bus.flit_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %0h expected 0", bus.flit_pending); end
    n_checks++; if (bus.flit_valid !== '0) begin n_fail++; $display("FAIL reset_flit_valid: got %0h expected 0", bus.flit_valid); end
    n_checks++; if (bus.ownership !== '0) begin n_fail++; $display("FAIL reset_ownership: got %0h expected 0", bus.ownership); end
    n_checks++; if (bus.credit_cnt !== '0) begin n_fail++; $display("FAIL reset_credit: got %0h expected 0", bus.credit_cnt); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    bus.link_up = 1'b1; bus.own_flit[0] = 1'b1; bus.lcrd_v = 3'b001;
    tick();
    bus.own_flit = '0; bus.lcrd_v = '0;
    serve(1, '0);
    n_checks++; if ({s_to_r, s_to_f} !== 2'b00) begin n_fail++; $display("FAIL single_timeout: got %0b expected 00", {s_to_r, s_to_f}); end
    n_checks++; if (s_ch !== 2'd0 || s_addr !== 4'd0) begin n_fail++; $display("FAIL single_read: got ch %0d addr %0d expected ch 0 addr 0", s_ch, s_addr); end
    n_checks++; if (s_req2 !== 1'b0) begin n_fail++; $display("FAIL single_req_width: got %0b expected 0", s_req2); end
    n_checks++; if (s_fv !== 3'b001 || s_lat != 2) begin n_fail++; $display("FAIL single_flit: got fv %0b lat %0d expected fv 001 lat 2", s_fv, s_lat); end
    n_checks++; if (bus.ownership !== '0) begin n_fail++; $display("FAIL single_own: got %0h expected 0", bus.ownership); end
    n_checks++; if (crd_of(0) != 0) begin n_fail++; $display("FAIL single_credit: got %0d expected 0", crd_of(0)); end
  endtask

  task automatic test_rr_order();
    logic [NUM_CH-1:0] ev;
    do_reset();
    bus.link_up = 1'b1; bus.lcrd_v = 3'b111;
    repeat (2) tick();
    bus.lcrd_v = '0;
    bus.own_flit[0] = 1'b1; bus.own_flit[15] = 1'b1; bus.own_flit[30] = 1'b1;
    tick();
    bus.own_flit = '0;
    for (int k = 0; k < 3; k++) begin
      serve(int'($urandom_range(1, 3)), '0);
      ev = '0; ev[k] = 1'b1;
      n_checks++; if ({s_to_r, s_to_f} !== 2'b00 || s_ch !== CHW'(k) || s_addr !== 4'd0 || s_fv !== ev) begin
        n_fail++; $display("FAIL rr_order_%0d: got ch %0d addr %0d fv %0b expected ch %0d addr 0 fv %0b", k, s_ch, s_addr, s_fv, k, ev);
      end
    end
    bus.own_flit[1] = 1'b1; bus.own_flit[31] = 1'b1;
    tick();
    bus.own_flit = '0;
    serve(2, '0);
    n_checks++; if (s_to_r !== 1'b0 || s_ch !== 2'd0 || s_addr !== 4'd1) begin n_fail++; $display("FAIL rr_wrap_first: got ch %0d addr %0d expected ch 0 addr 1", s_ch, s_addr); end
    serve(1, '0);
    n_checks++; if (s_to_r !== 1'b0 || s_ch !== 2'd2 || s_addr !== 4'd1) begin n_fail++; $display("FAIL rr_wrap_second: got ch %0d addr %0d expected ch 2 addr 1", s_ch, s_addr); end
    n_checks++; if (crd_of(0) != 0 || crd_of(1) != 1 || crd_of(2) != 0) begin n_fail++; $display("FAIL rr_credits: got %0d %0d %0d expected 0 1 0", crd_of(0), crd_of(1), crd_of(2)); end
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    bus.link_up = 1'b1; bus.lcrd_v = 3'b010;
    repeat (15) tick();
    bus.lcrd_v = '0;
    for (int i = 0; i < DEPTH; i++) bus.own_flit[DEPTH + i] = 1'b1;
    tick();
    bus.own_flit = '0;
    for (int s = 0; s < DEPTH; s++) begin
      serve(int'($urandom_range(1, 2)), '0);
      n_checks++; if ({s_to_r, s_to_f} !== 2'b00 || s_ch !== 2'd1 || s_addr !== AW'(s)) begin
        n_fail++; $display("FAIL wrap_send_%0d: got ch %0d addr %0d expected ch 1 addr %0d", s, s_ch, s_addr, s);
      end
    end
    n_checks++; if (crd_of(1) != 0) begin n_fail++; $display("FAIL wrap_credit: got %0d expected 0", crd_of(1)); end
    n_checks++; if (bus.ownership !== '0) begin n_fail++; $display("FAIL wrap_own: got %0h expected 0", bus.ownership); end
    bus.own_flit[DEPTH] = 1'b1; bus.lcrd_v = 3'b010;
    tick();
    bus.own_flit = '0; bus.lcrd_v = '0;
    serve(1, '0);
    n_checks++; if ({s_to_r, s_to_f} !== 2'b00 || s_ch !== 2'd1 || s_addr !== 4'd0) begin n_fail++; $display("FAIL wrap_reuse: got ch %0d addr %0d expected ch 1 addr 0", s_ch, s_addr); end
  endtask

  task automatic test_credit_sat();
    do_reset();
    bus.link_up = 1'b1; bus.lcrd_v = 3'b100;
    repeat (17) tick();
    bus.lcrd_v = '0;
    n_checks++; if (crd_of(2) != MAX_CRD) begin n_fail++; $display("FAIL crd_saturate: got %0d expected %0d", crd_of(2), MAX_CRD); end
    bus.own_flit[30] = 1'b1; bus.own_flit[31] = 1'b1;
    tick();
    bus.own_flit = '0;
    serve(1, 3'b100);
    n_checks++; if (s_to_f !== 1'b0 || s_fv !== 3'b100 || crd_of(2) != MAX_CRD) begin n_fail++; $display("FAIL crd_coincident: got fv %0b credit %0d expected fv 100 credit %0d", s_fv, crd_of(2), MAX_CRD); end
    serve(2, '0);
    n_checks++; if (s_to_f !== 1'b0 || s_addr !== 4'd1 || crd_of(2) != MAX_CRD - 1) begin n_fail++; $display("FAIL crd_decrement: got addr %0d credit %0d expected addr 1 credit %0d", s_addr, crd_of(2), MAX_CRD - 1); end
  endtask

  task automatic test_link_drop();
    logic seen;
    do_reset();
    bus.link_up = 1'b1; bus.lcrd_v = 3'b001; bus.own_flit[0] = 1'b1;
    tick();
    bus.lcrd_v = '0; bus.own_flit = '0;
    wait_read_req();
    n_checks++; if (s_to_r !== 1'b0) begin n_fail++; $display("FAIL drop_read: got timeout %0b expected 0", s_to_r); end
    tick();
    bus.rd_vld = 1'b1; bus.link_up = 1'b0;
    tick();
    bus.rd_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.flit_valid !== '0 || bus.flit_pending !== 1'b1 || crd_of(0) != 0 || bus.read_req !== 1'b0) begin
        n_fail++; $display("FAIL drop_stall_%0d: got fv %0b pend %0b crd %0d req %0b expected 0 1 0 0", i, bus.flit_valid, bus.flit_pending, crd_of(0), bus.read_req);
      end
      tick();
    end
    bus.link_up = 1'b1;
    tick();
    n_checks++; if (bus.flit_valid !== '0 || bus.flit_pending !== 1'b1) begin n_fail++; $display("FAIL drop_no_credit: got fv %0b pend %0b expected 0 1", bus.flit_valid, bus.flit_pending); end
    bus.lcrd_v = 3'b001;
    tick();
    bus.lcrd_v = '0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.flit_valid !== '0) begin seen = 1'b1; s_fv = bus.flit_valid; break; end
      tick();
    end
    n_checks++; if (seen !== 1'b1 || s_fv !== 3'b001) begin n_fail++; $display("FAIL drop_resume: got seen %0b fv %0b expected 1 001", seen, s_fv); end
    n_checks++; if (bus.ownership !== '0 || crd_of(0) != 0) begin n_fail++; $display("FAIL drop_final: got own %0h crd %0d expected 0 0", bus.ownership, crd_of(0)); end
  endtask

  task automatic test_own_repeat();
    logic [NB-1:0] e;
    do_reset();
    bus.link_up = 1'b1; bus.own_flit[3] = 1'b1;
    tick();
    bus.own_flit = '0;
    e = '0; e[3] = 1'b1;
    n_checks++; if (bus.ownership !== e) begin n_fail++; $display("FAIL own_set: got %0h expected %0h", bus.ownership, e); end
    bus.own_flit[3] = 1'b1; bus.own_flit[20] = 1'b1;
    tick();
    bus.own_flit = '0;
    e[20] = 1'b1;
    n_checks++; if (bus.ownership !== e || bus.read_req !== 1'b0) begin n_fail++; $display("FAIL own_repeat: got %0h req %0b expected %0h req 0", bus.ownership, bus.read_req, e); end
  endtask

  task automatic test_reset_midflight();
    logic bad;
    do_reset();
    bus.link_up = 1'b1; bus.lcrd_v = 3'b001; bus.own_flit[0] = 1'b1;
    tick();
    bus.lcrd_v = '0; bus.own_flit = '0;
    wait_read_req();
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (s_to_r !== 1'b0) begin n_fail++; $display("FAIL midrst_read: got timeout %0b expected 0", s_to_r); end
    n_checks++; if ({bus.read_req, bus.flit_pending, bus.flit_valid, bus.read_ch, bus.read_addr} !== '0) begin
      n_fail++; $display("FAIL midrst_ctrl: got req %0b pend %0b fv %0b ch %0d addr %0d expected all 0", bus.read_req, bus.flit_pending, bus.flit_valid, bus.read_ch, bus.read_addr);
    end
    n_checks++; if (bus.ownership !== '0 || bus.credit_cnt !== '0) begin n_fail++; $display("FAIL midrst_state: got own %0h crd %0h expected 0 0", bus.ownership, bus.credit_cnt); end
    bus.rd_vld = 1'b1;
    tick();
    bus.rd_vld = 1'b0; rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.flit_valid !== '0 || bus.read_req !== 1'b0) bad = 1'b1;
      tick();
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL midrst_no_send: got activity %0b expected 0", bad); end
  endtask

  task automatic test_random();
    int c[NUM_CH];
    logic [NUM_CH-1:0] ev;
    int extra;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      bus.link_up = 1'b1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        c[ch] = int'($urandom_range(0, MAX_CRD + 2));
        m_crd[ch] = (c[ch] > MAX_CRD) ? MAX_CRD : c[ch];
      end
      for (int t = 0; t < MAX_CRD + 2; t++) begin
        for (int ch = 0; ch < NUM_CH; ch++) bus.lcrd_v[ch] = (t < c[ch]);
        tick();
      end
      bus.lcrd_v = '0;
      for (int ch = 0; ch < NUM_CH; ch++)
        for (int i = 0; i < DEPTH; i++) begin
          m_own[ch][i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
          bus.own_flit[ch*DEPTH+i] = (m_own[ch][i] != 0);
        end
      tick();
      bus.own_flit = '0;
      model_plan();
      for (int k = 0; k < exp_ch.size(); k++) begin
        serve(int'($urandom_range(1, 3)), '0);
        ev = '0; ev[exp_ch[k]] = 1'b1;
        n_checks++; if ({s_to_r, s_to_f} !== 2'b00 || s_ch !== CHW'(exp_ch[k]) || s_addr !== AW'(exp_addr[k]) || s_fv !== ev || s_req2 !== 1'b0) begin
          n_fail++; $display("FAIL rand_%0d_send_%0d: got ch %0d addr %0d fv %0b to %0b%0b expected ch %0d addr %0d fv %0b", r, k, s_ch, s_addr, s_fv, s_to_r, s_to_f, exp_ch[k], exp_addr[k], ev);
        end
        if (s_to_r || s_to_f) break;
      end
      extra = 0;
      repeat (8) begin
        if (bus.read_req === 1'b1) extra++;
        tick();
      end
      n_checks++; if (extra != 0) begin n_fail++; $display("FAIL rand_%0d_extra_reads: got %0d expected 0", r, extra); end
      n_checks++; if (bus.ownership !== model_own_vec()) begin n_fail++; $display("FAIL rand_%0d_own: got %0h expected %0h", r, bus.ownership, model_own_vec()); end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        n_checks++; if (crd_of(ch) != m_crd[ch]) begin n_fail++; $display("FAIL rand_%0d_crd_%0d: got %0d expected %0d", r, ch, crd_of(ch), m_crd[ch]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.own_flit = '0; bus.link_up = 1'b0; bus.lcrd_v = '0; bus.rd_vld = 1'b0;
    tick();
    test_reset();
    test_single();
    test_rr_order();
    test_ptr_wrap();
    test_credit_sat();
    test_link_drop();
    test_own_repeat();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/chi_txflit_mgmt_mc.md
# chi_txflit_mgmt_mc

Multi-channel, parametrised successor to the single-channel CHI TX flit manager. Tracks software-granted ownership of NUM_CH × DEPTH flit buffer slots and keeps a per-channel link-credit counter fed by returned L-credits. Picks the next eligible channel round-robin, reads the flit from buffer memory, and signals flit transmission on the link. Sits between the bridge register/flit-buffer block and the CHI TX link interface.

## Interface
Parameters:
- NUM_CH, 3, number of TX channels (e.g. REQ/RSP/DAT); ≥1
- DEPTH, 15, flit slots per channel; ≥2
- MAX_CRD, 15, credit counter saturation value
- Derived: AW = clog2(DEPTH), CHW = max(1, clog2(NUM_CH)), CW = clog2(MAX_CRD+1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- own_flit  in  NUM_CH*DEPTH  ownership set pulses; bit ch*DEPTH+i grants slot i of channel ch
- link_up  in  1  TX link active
- lcrd_v  in  NUM_CH  one-cycle credit-return pulse per channel
- rd_vld  in  1  flit buffer read data valid, response to read_req
- read_req  out  1  one-cycle buffer read request
- read_ch  out  CHW  channel of read
- read_addr  out  AW  slot of read
- flit_pending  out  1  a flit is read or awaiting send
- flit_valid  out  NUM_CH  one-hot, one-cycle flit-sent strobe
- ownership  out  NUM_CH*DEPTH  current ownership bits
- credit_cnt  out  NUM_CH*CW  current credit per channel

## Operation
- Ownership bit: set by own_flit when 0; own_flit ignored when already 1; cleared when its flit is sent. A set and a clear of the same bit in one cycle leave it 0.
- Per-channel read pointer rd_ptr[ch]: starts at 0, advances on send, wraps DEPTH-1 → 0.
- Channel eligible when ownership[ch][rd_ptr[ch]]=1, credit_cnt[ch]>0 and link_up=1.
- Credit counter: +1 on lcrd_v, saturating at MAX_CRD (extra pulse dropped). −1 on send. Increment and send in the same cycle leave it unchanged. Forced to 0 in any cycle link_up=0, overriding lcrd_v.
- Round-robin: priority pointer starts at channel 0. After a send on channel g it moves to (g+1) mod NUM_CH. Search order: pointer, pointer+1, …
- FSM:
  - IDLE: if any channel is eligible, latch grant g. Register read_req=1, read_ch=g, read_addr=rd_ptr[g]. Go to WAIT_DATA.
  - WAIT_DATA: wait for rd_vld, then go to SEND. rd_vld in any other state is ignored.
  - SEND: if link_up and credit_cnt[g]>0, register flit_valid[g]=1, clear the ownership bit, decrement credit, advance rd_ptr[g] and the RR pointer, then go to IDLE. Otherwise hold in SEND (flit retained, no re-read).
- flit_pending = 1 iff state ∈ {WAIT_DATA, SEND}.
- read_ch and read_addr hold their last value outside read_req.

## Timing
- Reset: state IDLE; all outputs 0; ownership, credits, rd_ptr and RR pointer all 0. Reset mid-operation aborts any in-flight flit without sending it.
- Eligible in IDLE at cycle N → read_req high at N+1 (exactly one cycle).
- Earliest valid rd_vld is N+2. rd_vld at M → SEND at M+1 → flit_valid high at M+2. Ownership clear and credit decrement are visible at M+2.
- Back-to-back: IDLE at M+2 can issue the next read_req at M+3. Minimum 4 cycles per flit.
- Link drop during SEND zeroes credits; the send stalls until link_up=1 and a credit returns.

## Test plan
- Reset, then own_flit bit 0 (ch0 slot0), 1 lcrd_v on ch0, link_up=1, rd_vld 1 cycle after read_req → read_req with read_ch=0, read_addr=0; flit_valid=3'b001 4 cycles after read_req's cycle −1; ownership=0; credit_cnt[0]=0.
- Ch0–ch2 slot0 owned, 2 credits each → send order ch0, ch1, ch2; RR pointer returns to 0.
- Ch1 owns all 15 slots, 15 credits → read_addr 0..14, then slot 0 re-owned → read_addr wraps to 0; credit_cnt[1]=0 after 15 sends.
- 17 lcrd_v pulses on ch2 → credit_cnt[2]=15. lcrd_v coincident with a ch2 send → count unchanged.
- Drop link_up while in SEND → credits 0, no flit_valid, flit_pending stays 1. Restore link plus 1 credit → flit sent.
- own_flit repeated on an owned bit → ignored. Assert rst during WAIT_DATA → all outputs 0 next cycle, no flit_valid.
